param_universal_shift_register: RTL and testbench



---
 rtl/param_universal_shift_register_if.sv | 25 ++
 rtl/param_universal_shift_register.sv | 96 +++++++++
 tb/tb_param_universal_shift_register.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/param_universal_shift_register_if.sv
// Bus bundle for the universal shift register: op/data/burst controls in, register state out.
interface param_universal_shift_register_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic [2:0]       op;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output op, serial_in, parallel_in, start, burst_len,
    input  parallel_out, serial_out, busy, done
  );

  modport slave (
    input  op, serial_in, parallel_in, start, burst_len,
    output parallel_out, serial_out, busy, done
  );
endinterface

// File: rtl/param_universal_shift_register.sv
// WIDTH-bit universal shift register (shift/rotate/load/hold) with a counted burst engine
// that repeats one latched op burst_len times under a start/busy/done handshake.
module param_universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  param_universal_shift_register_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [2:0]       burst_op;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] q;
  logic             so;
  logic             busy_q;
  logic             done_q;

  logic [2:0]       act_op;
  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;

  // Data-path result of whichever op is active this cycle (live op in IDLE, latched op in BURST).
  always_comb begin
    act_op = (state == BURST) ? burst_op : bus.op;
    q_nxt  = q;
    so_nxt = so;
    case (act_op)
      OP_SHL:  begin q_nxt = {q[WIDTH-2:0], bus.serial_in}; so_nxt = q[WIDTH-1]; end
      OP_SHR:  begin q_nxt = {bus.serial_in, q[WIDTH-1:1]}; so_nxt = q[0];       end
      OP_ASR:  begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};    so_nxt = q[0];       end
      OP_ROL:  begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};    so_nxt = q[WIDTH-1]; end
      OP_ROR:  begin q_nxt = {q[0], q[WIDTH-1:1]};          so_nxt = q[0];       end
      OP_LOAD: q_nxt = bus.parallel_in;
      OP_HOLD: ;
      default: ;
    endcase
  end

  // Control FSM and data registers; start wins over op on the launching edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      burst_op <= OP_HOLD;
      rem      <= '0;
      q        <= '0;
      so       <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= BURST;
            burst_op <= bus.op;
            rem      <= bus.burst_len;
            busy_q   <= 1'b1;
          end else begin
            q  <= q_nxt;
            so <= so_nxt;
          end
        end
        BURST: begin
          if (rem != '0) begin
            q   <= q_nxt;
            so  <= so_nxt;
            rem <= rem - CNT_W'(1);
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.parallel_out = q;
  assign bus.serial_out   = so;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_param_universal_shift_register.sv
// Directed bench for param_universal_shift_register: arithmetic reference model checked every
// cycle, plus hand-computed literal expectations along the directed sequence.
module tb_param_universal_shift_register;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int MOD = 256;
  localparam int MSB = 128;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  param_universal_shift_register_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  param_universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: register value as an integer, ops as multiply/divide/modulo arithmetic.
  int m_q, m_so, m_busy, m_done, m_rem, m_op;

  function automatic void apply(input int o, input int sin, input int pin);
    int out;
    case (o)
      1: begin out = m_q / MSB; m_q = (m_q * 2) % MOD + sin;               m_so = out; end
      2: begin out = m_q % 2;   m_q = m_q / 2 + sin * MSB;                 m_so = out; end
      3: begin out = m_q % 2;   m_q = m_q / 2 + ((m_q >= MSB) ? MSB : 0);  m_so = out; end
      4: begin out = m_q / MSB; m_q = (m_q * 2) % MOD + out;               m_so = out; end
      5: begin out = m_q % 2;   m_q = m_q / 2 + out * MSB;                 m_so = out; end
      6: m_q = pin;
      default: ;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0; m_op = 0;
    end else begin
      m_done = 0;
      if (m_busy == 0) begin
        if (bus.start) begin
          m_busy = 1; m_op = int'(bus.op); m_rem = int'(bus.burst_len);
        end else begin
          apply(int'(bus.op), int'(bus.serial_in), int'(bus.parallel_in));
        end
      end else if (m_rem > 0) begin
        apply(m_op, int'(bus.serial_in), int'(bus.parallel_in));
        m_rem = m_rem - 1;
      end else begin
        m_busy = 0; m_done = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_parallel_out", int'(bus.parallel_out), m_q);
      chk("model_serial_out",   int'(bus.serial_out),   m_so);
      chk("model_busy",         int'(bus.busy),         m_busy);
      chk("model_done",         int'(bus.done),         m_done);
    end
  end

  task automatic cyc(input int o, input int sin, input int pin, input int st, input int len);
    bus.op          = 3'(o);
    bus.serial_in   = 1'(sin);
    bus.parallel_in = WIDTH'(pin);
    bus.start       = 1'(st);
    bus.burst_len   = CNT_W'(len);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input int pout, input int so, input int bsy, input int dn);
    chk({name, "_pout"}, int'(bus.parallel_out), pout);
    chk({name, "_sout"}, int'(bus.serial_out),   so);
    chk({name, "_busy"}, int'(bus.busy),         bsy);
    chk({name, "_done"}, int'(bus.done),         dn);
  endtask

  task automatic mid_cycle_reset(input string name);
    #2 reset = 1'b1;
    #1 expect_out(name, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 3'd0; bus.serial_in = 1'b0; bus.parallel_in = '0; bus.start = 1'b0; bus.burst_len = '0;
    repeat (2) @(posedge clk);
    #1 expect_out("reset", 0, 0, 0, 0);
    #3 reset = 1'b0;
    chk_en = 1;

    // Load, then an asynchronous reset between edges clears everything at once.
    cyc(6, 0, 'hE5, 0, 0); expect_out("load", 'hE5, 0, 0, 0);
    cyc(4, 0, 0, 0, 0);    expect_out("rol_pre_rst", 'hCB, 1, 0, 0);
    mid_cycle_reset("async_rst");

    cyc(6, 0, 'hE5, 0, 0); cyc(1, 0, 0, 0, 0); expect_out("shl", 'hCA, 1, 0, 0);
    cyc(6, 0, 'hE5, 0, 0); cyc(2, 1, 0, 0, 0); expect_out("shr", 'hF2, 1, 0, 0);
    cyc(6, 0, 'h65, 0, 0); cyc(3, 0, 0, 0, 0); expect_out("asr_pos", 'h32, 1, 0, 0);
    cyc(6, 0, 'hE5, 0, 0); cyc(3, 0, 0, 0, 0); expect_out("asr_neg", 'hF2, 1, 0, 0);
    cyc(6, 0, 'hE5, 0, 0); cyc(4, 0, 0, 0, 0); expect_out("rol", 'hCB, 1, 0, 0);
    cyc(6, 0, 'hE5, 0, 0); cyc(5, 0, 0, 0, 0); expect_out("ror", 'hF2, 1, 0, 0);
    cyc(0, 1, 'h00, 0, 0); expect_out("hold", 'hF2, 1, 0, 0);
    cyc(7, 1, 'h00, 0, 0); expect_out("op7_hold", 'hF2, 1, 0, 0);

    // Burst ROL x3 from 0x81; op/start wiggled during busy must be ignored.
    cyc(6, 0, 'h81, 0, 0);
    cyc(4, 0, 0, 1, 3);    expect_out("burst_e0", 'h81, 1, 1, 0);
    cyc(1, 1, 'hFF, 1, 7); expect_out("burst_e1", 'h03, 1, 1, 0);
    cyc(6, 1, 'hFF, 0, 7); expect_out("burst_e2", 'h06, 0, 1, 0);
    cyc(2, 1, 'hFF, 1, 7); expect_out("burst_e3", 'h0C, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);    expect_out("burst_e4", 'h0C, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);    expect_out("burst_e5", 'h0C, 0, 0, 0);

    // Zero-length burst launched with op=SHL: no shift, done after one edge.
    cyc(1, 1, 0, 1, 0);    expect_out("len0_e0", 'h0C, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);    expect_out("len0_e1", 'h0C, 0, 0, 1);
    // Start during the done cycle is accepted: SHR x2 with serial_in=1.
    cyc(2, 1, 0, 1, 2);    expect_out("redo_e0", 'h0C, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);    expect_out("redo_e1", 'h86, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);    expect_out("redo_e2", 'hC3, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);    expect_out("redo_e3", 'hC3, 0, 0, 1);

    // Burst of LOAD reloads the live parallel_in every burst cycle.
    cyc(6, 0, 'h11, 1, 2);
    cyc(0, 0, 'h5A, 0, 0);
    cyc(0, 0, 'h3C, 0, 0); expect_out("burst_load", 'h3C, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // start held high: back-to-back single-op ROR bursts (model-checked).
    for (int i = 0; i < 7; i++) cyc(5, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Reset four shifts into a ROR x10 burst: immediate clear, no done afterwards.
    cyc(6, 0, 'h01, 0, 0);
    cyc(5, 0, 0, 1, 10);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); expect_out("ror_burst_4", 'h10, 0, 1, 0);
    mid_cycle_reset("rst_mid_burst");
    cyc(0, 0, 0, 0, 0);    expect_out("post_rst_idle", 0, 0, 0, 0);
    cyc(6, 0, 'hA5, 0, 0); expect_out("post_rst_load", 'hA5, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);    expect_out("post_rst_shl", 'h4B, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
